// File: rtl/isq_enq_stage_if.sv
// Enqueue-stage bundle: dispatch push side, issue-queue pop side, condition
// broadcast and rollback flush. master = environment, slave = the stage.
interface isq_enq_stage_if #(
    parameter int DATA_WIDTH   = 248,
    parameter int COND_WIDTH   = 2,
    parameter int ROB_SIZE_LOG = 6,
    parameter int DEPTH        = 4
);
    localparam int RID_W = ROB_SIZE_LOG + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  disp_valid;
    logic                  disp_ready;
    logic [DATA_WIDTH-1:0] disp_data;
    logic [COND_WIDTH-1:0] disp_condition;

    logic                  isq_enq_valid;
    logic                  isq_enq_ready;
    logic [DATA_WIDTH-1:0] isq_enq_data;
    logic [COND_WIDTH-1:0] isq_enq_condition;

    logic                  update_condition_valid;
    logic [RID_W-1:0]      update_condition_robid;
    logic [COND_WIDTH-1:0] update_condition_mask;
    logic [COND_WIDTH-1:0] update_condition_in;

    logic                  flush_valid;
    logic [RID_W-1:0]      flush_robid;

    logic [CNT_W-1:0]      count;

    modport master (
        output disp_valid, disp_data, disp_condition, isq_enq_ready,
               update_condition_valid, update_condition_robid,
               update_condition_mask, update_condition_in,
               flush_valid, flush_robid,
        input  disp_ready, isq_enq_valid, isq_enq_data, isq_enq_condition, count
    );

    modport slave (
        input  disp_valid, disp_data, disp_condition, isq_enq_ready,
               update_condition_valid, update_condition_robid,
               update_condition_mask, update_condition_in,
               flush_valid, flush_robid,
        output disp_ready, isq_enq_valid, isq_enq_data, isq_enq_condition, count
    );
endinterface

// File: rtl/isq_enq_stage.sv
// In-order enqueue FIFO in front of the issue queue: snoops condition
// broadcasts for waiting entries and truncates its younger suffix on rollback.
module isq_enq_stage #(
    parameter int DATA_WIDTH   = 248,
    parameter int COND_WIDTH   = 2,
    parameter int ROB_SIZE_LOG = 6,
    parameter int DEPTH        = 4
) (
    input  logic           clock,
    input  logic           reset,
    isq_enq_stage_if.slave io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RID_W = ROB_SIZE_LOG + 1;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [COND_WIDTH-1:0] cond_q   [DEPTH];
    logic [COND_WIDTH-1:0] cond_d   [DEPTH];
    logic [DEPTH-1:0]      younger;

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] survivors;
    logic             push, pop;

    function automatic logic [COND_WIDTH-1:0] merge_cond(
        input logic [COND_WIDTH-1:0] cond,
        input logic [RID_W-1:0]      rid,
        input logic                  upd_valid,
        input logic [RID_W-1:0]      upd_rid,
        input logic [COND_WIDTH-1:0] upd_mask,
        input logic [COND_WIDTH-1:0] upd_in
    );
        if (upd_valid && (upd_rid == rid))
            return (cond & ~upd_mask) | (upd_in & upd_mask);
        return cond;
    endfunction

    // Age compare across the wrap bit: the MSB flips the sense of the index compare.
    function automatic logic is_younger(input logic [RID_W-1:0] flush_rid,
                                        input logic [RID_W-1:0] rid);
        return flush_rid[RID_W-1] ^ rid[RID_W-1] ^
               (flush_rid[RID_W-2:0] < rid[RID_W-2:0]);
    endfunction

    assign io.disp_ready    = !reset && (count_q < CNT_W'(DEPTH)) && !io.flush_valid;
    assign io.isq_enq_valid = (count_q != '0) && !io.flush_valid;
    assign io.isq_enq_data  = data_mem[head_q];
    assign io.count         = count_q;

    assign push = io.disp_valid && io.disp_ready;
    assign pop  = io.isq_enq_valid && io.isq_enq_ready;

    assign io.isq_enq_condition = merge_cond(cond_q[head_q],
                                             data_mem[head_q][DATA_WIDTH-1 -: RID_W],
                                             io.update_condition_valid,
                                             io.update_condition_robid,
                                             io.update_condition_mask,
                                             io.update_condition_in);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign younger[gi] = is_younger(io.flush_robid,
                                            data_mem[gi][DATA_WIDTH-1 -: RID_W]);
            assign cond_d[gi] = (push && (tail_q == PTR_W'(gi)))
                ? merge_cond(io.disp_condition,
                             io.disp_data[DATA_WIDTH-1 -: RID_W],
                             io.update_condition_valid, io.update_condition_robid,
                             io.update_condition_mask, io.update_condition_in)
                : merge_cond(cond_q[gi],
                             data_mem[gi][DATA_WIDTH-1 -: RID_W],
                             io.update_condition_valid, io.update_condition_robid,
                             io.update_condition_mask, io.update_condition_in);
        end
    endgenerate

    // Younger entries form a suffix, so survivors is the run of old entries from head.
    always_comb begin
        logic             stop;
        logic [PTR_W-1:0] idx;
        survivors = '0;
        stop      = 1'b0;
        idx       = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (!stop && (CNT_W'(k) < count_q) && !younger[idx])
                survivors = survivors + CNT_W'(1);
            else
                stop = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            data_mem[tail_q] <= io.disp_data;
        for (int i = 0; i < DEPTH; i++)
            cond_q[i] <= cond_d[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (io.flush_valid) begin
            count_q <= survivors;
            tail_q  <= head_q + survivors[PTR_W-1:0];
        end else begin
            if (push)
                tail_q <= tail_q + PTR_W'(1);
            if (pop)
                head_q <= head_q + PTR_W'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_isq_enq_stage.sv
// Directed vector bench for isq_enq_stage: each row drives one cycle and checks
// the pre-edge outputs that earlier rows should have produced.
module tb_isq_enq_stage;
    localparam int DW = 248;
    localparam int CW = 2;
    localparam int RW = 7;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    isq_enq_stage_if #(.DATA_WIDTH(DW), .COND_WIDTH(CW), .ROB_SIZE_LOG(6), .DEPTH(4)) bus ();

    isq_enq_stage #(.DATA_WIDTH(DW), .COND_WIDTH(CW), .ROB_SIZE_LOG(6), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus.slave)
    );

    typedef struct {
        logic          dv;
        logic [RW-1:0] drob;
        logic [CW-1:0] dcond;
        logic          rdy;
        logic          uv;
        logic [RW-1:0] urob;
        logic [CW-1:0] umask;
        logic [CW-1:0] uin;
        logic          fv;
        logic [RW-1:0] frob;
        logic [2:0]    ecnt;
        logic          edr;
        logic          ev;
        logic [RW-1:0] erob;
        logic [CW-1:0] econd;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [DW-1:0] mkdata(input logic [RW-1:0] rob);
        return {rob, {34{rob}}, 3'b101};
    endfunction

    function automatic vec_t mk(input logic dv, input logic [RW-1:0] drob,
                                input logic [CW-1:0] dcond, input logic rdy,
                                input logic uv, input logic [RW-1:0] urob,
                                input logic [CW-1:0] umask, input logic [CW-1:0] uin,
                                input logic fv, input logic [RW-1:0] frob,
                                input logic [2:0] ecnt, input logic edr, input logic ev,
                                input logic [RW-1:0] erob, input logic [CW-1:0] econd);
        vec_t v;
        v.dv = dv; v.drob = drob; v.dcond = dcond; v.rdy = rdy;
        v.uv = uv; v.urob = urob; v.umask = umask; v.uin = uin;
        v.fv = fv; v.frob = frob;
        v.ecnt = ecnt; v.edr = edr; v.ev = ev; v.erob = erob; v.econd = econd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.disp_valid = 0; bus.disp_data = '0; bus.disp_condition = '0;
        bus.isq_enq_ready = 0; bus.update_condition_valid = 0;
        bus.update_condition_robid = '0; bus.update_condition_mask = '0;
        bus.update_condition_in = '0; bus.flush_valid = 0; bus.flush_robid = '0;
    endtask

    initial begin
        // dv drob dcond rdy | uv urob mask in | fv frob | cnt dr v rob cond
        // three entries, held, then popped in order
        vecs.push_back(mk(1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(1,  3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 1, 0));
        vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 1, 0));
        vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 1, 2, 0));
        vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // fill to full, then stream 20..27 across the pointer wrap
        vecs.push_back(mk(1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 21, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 20, 0));
        vecs.push_back(mk(1, 22, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 20, 0));
        vecs.push_back(mk(1, 23, 3, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 20, 0));
        vecs.push_back(mk(1, 24, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 20, 0));
        vecs.push_back(mk(1, 24, 0, 1, 0, 0, 0, 0, 0, 0, 4, 0, 1, 20, 0));
        vecs.push_back(mk(1, 24, 0, 1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 21, 1));
        vecs.push_back(mk(1, 25, 1, 1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 22, 2));
        vecs.push_back(mk(1, 26, 2, 1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 23, 3));
        vecs.push_back(mk(1, 27, 3, 1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 24, 0));
        vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 25, 1));
        vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 1, 26, 2));
        vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 27, 3));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // condition snooping: stored update, pop-cycle merge, push-cycle merge, no-match
        vecs.push_back(mk(1,  5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1, 5, 1, 1, 0, 0, 1, 1, 1, 5, 1));
        vecs.push_back(mk(0,  0, 0, 1, 1, 5, 2, 2, 0, 0, 1, 1, 1, 5, 3));
        vecs.push_back(mk(1,  7, 0, 0, 1, 7, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1, 8, 3, 3, 0, 0, 1, 1, 1, 7, 1));
        vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // flush at robid 11 with survivor update on robid 10; push/pop blocked
        vecs.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 10, 0));
        vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 10, 0));
        vecs.push_back(mk(1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 10, 0));
        vecs.push_back(mk(1, 14, 0, 1, 1, 10, 1, 1, 1, 11, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 1, 10, 1));
        vecs.push_back(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 11, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // wrap-bit flushes
        vecs.push_back(mk(1, 7'h3E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 7'h3F, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7'h3E, 0));
        vecs.push_back(mk(1, 7'h40, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 7'h3E, 0));
        vecs.push_back(mk(1, 7'h41, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 7'h3E, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7'h3F, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7'h3D, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        $display("reset: count=%0d valid=%0b ready=%0b", bus.count, bus.isq_enq_valid, bus.disp_ready);
        chk("reset_count", 256'(bus.count), 256'(0));
        chk("reset_valid", 256'(bus.isq_enq_valid), 256'(0));
        chk("reset_ready", 256'(bus.disp_ready), 256'(0));
        reset = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.disp_valid             = vecs[i].dv;
            bus.disp_data              = mkdata(vecs[i].drob);
            bus.disp_condition         = vecs[i].dcond;
            bus.isq_enq_ready          = vecs[i].rdy;
            bus.update_condition_valid = vecs[i].uv;
            bus.update_condition_robid = vecs[i].urob;
            bus.update_condition_mask  = vecs[i].umask;
            bus.update_condition_in    = vecs[i].uin;
            bus.flush_valid            = vecs[i].fv;
            bus.flush_robid            = vecs[i].frob;
            #1;
            $display("vec %0d: count=%0d ready=%0b valid=%0b head=%0h cond=%0b",
                     i, bus.count, bus.disp_ready, bus.isq_enq_valid,
                     bus.isq_enq_data[DW-1 -: RW], bus.isq_enq_condition);
            chk($sformatf("v%0d_count", i), 256'(bus.count), 256'(vecs[i].ecnt));
            chk($sformatf("v%0d_ready", i), 256'(bus.disp_ready), 256'(vecs[i].edr));
            chk($sformatf("v%0d_valid", i), 256'(bus.isq_enq_valid), 256'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_data", i), 256'(bus.isq_enq_data), 256'(mkdata(vecs[i].erob)));
                chk($sformatf("v%0d_cond", i), 256'(bus.isq_enq_condition), 256'(vecs[i].econd));
            end
            @(posedge clock);
            @(negedge clock);
        end

        // reset asserted mid-stream with three entries queued
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.disp_valid = 1;
            bus.disp_data  = mkdata(7'(40 + i));
            @(posedge clock);
            @(negedge clock);
        end
        bus.disp_valid = 0;
        #1;
        chk("mid_count_before", 256'(bus.count), 256'(3));
        reset = 1;
        #1;
        chk("mid_ready_in_reset", 256'(bus.disp_ready), 256'(0));
        @(posedge clock);
        @(negedge clock);
        #1;
        $display("mid-reset: count=%0d valid=%0b", bus.count, bus.isq_enq_valid);
        chk("mid_count_after", 256'(bus.count), 256'(0));
        chk("mid_valid_after", 256'(bus.isq_enq_valid), 256'(0));
        reset = 0;
        #1;
        chk("mid_ready_release", 256'(bus.disp_ready), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/isq_enq_stage.md
# isq_enq_stage

Dispatch-side enqueue stage for the issue queue. A small in-order FIFO accepts renamed instructions from dispatch and presents them one at a time on the issue queue's enqueue handshake (valid/ready, data, condition). While instructions wait here it snoops writeback condition broadcasts, so no wakeup is lost between dispatch and issue-queue entry. It drops entries younger than a rollback flush robid.

## Interface
- DATA_WIDTH, 248: instruction payload width; robid is payload bits [247:241].
- COND_WIDTH, 2: condition (source-ready) bits per instruction.
- ROB_SIZE_LOG, 6: robid is ROB_SIZE_LOG+1 bits (MSB = wrap bit).
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- disp_valid  in  1  dispatch offers an instruction.
- disp_ready  out  1  stage accepts the instruction this cycle.
- disp_data  in  DATA_WIDTH  instruction payload.
- disp_condition  in  COND_WIDTH  initial condition bits.
- isq_enq_valid  out  1  head entry offered to the issue queue.
- isq_enq_ready  in  1  issue queue accepts the head entry.
- isq_enq_data  out  DATA_WIDTH  head payload.
- isq_enq_condition  out  COND_WIDTH  head condition with the same-cycle update merged in.
- update_condition_valid  in  1  writeback condition broadcast.
- update_condition_robid  in  ROB_SIZE_LOG+1  target robid.
- update_condition_mask  in  COND_WIDTH  bits to overwrite.
- update_condition_in  in  COND_WIDTH  new bit values.
- flush_valid  in  1  rollback flush, already qualified with the ROB rollback state.
- flush_robid  in  ROB_SIZE_LOG+1  flush point; strictly younger entries are killed.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage is a circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register. Entries remain in program order.
- Push occurs when `disp_valid && disp_ready`. It writes data and condition at tail, then increments tail and count.
- `disp_ready = !reset && (count < DEPTH) && !flush_valid`. It does not depend on `isq_enq_ready`.
- `isq_enq_valid = (count != 0) && !flush_valid`. Pop occurs when `isq_enq_valid && isq_enq_ready`; it increments head and decrements count.
- When push and pop happen in the same cycle, count is unchanged. This is legal at count==DEPTH only for the pop, because disp_ready is 0 when full.
- Condition merge: merged = (cond & ~mask) | (in & mask).
  - Applies when update_condition_valid is high and update_condition_robid equals the entry's payload[247:241].
  - Every stored entry that matches is updated at the clock edge.
  - An instruction pushed in the same cycle with a matching robid is stored with merged condition bits.
  - `isq_enq_condition` is the head condition merged combinationally with the same-cycle update, so a wakeup that coincides with the pop still reaches the issue queue.
- Flush: an entry e is younger when `flush_robid[MSB] ^ e_robid[MSB] ^ (flush_robid[MSB-1:0] < e_robid[MSB-1:0])` is 1.
  - Because entries are in order, the younger entries form a suffix of the FIFO.
  - Survivors = the number of consecutive non-younger entries counted from head.
  - At the flush edge: count <= survivors, tail <= head + survivors (mod DEPTH).
  - No push or pop occurs in a flush cycle. Condition updates in a flush cycle still apply to survivors.
- `isq_enq_data` = payload at head. Its value is don't-care when isq_enq_valid is 0.

## Timing
- While reset is high: head = tail = 0, count = 0, isq_enq_valid = 0, disp_ready = 0. All are registered or derived from registers; payload storage is not reset.
- Latency: an instruction pushed at edge N appears on isq_enq_valid from cycle N+1 if the FIFO was empty. Minimum dispatch-to-ISQ latency is 1 cycle.
- Sustained throughput is 1 instruction per cycle with isq_enq_ready held high and DEPTH >= 2.
- Once isq_enq_valid rises, head data must be held stable until accepted. The only exceptions are condition merges and a flush.
- Reset asserted mid-operation discards all entries at the next edge.

## Test plan
- Reset then push 3 entries (robid 1, 2, 3) with isq_enq_ready=0 -> count=3, isq_enq_valid=1, head robid 1. Then raise isq_enq_ready -> robids pop in order 1, 2, 3 on consecutive cycles, count reaches 0.
- Fill with DEPTH=4 -> disp_ready=0 at count=4. Pop and push in the same cycle afterwards -> count stays constant; 8 entries stream across the pointer wrap with order and data preserved.
- Entry robid 5 with condition 2'b00 stored; update robid 5, mask 2'b01, in 2'b01 -> stored condition 2'b01. An update on the pop cycle with mask 2'b10, in 2'b10 -> isq_enq_condition=2'b11. Push robid 7 with the same-cycle update for robid 7 -> stored condition is the merged value.
- Entries robid 10, 11, 12, 13 queued; flush_robid 11 -> count=2, then robids 10 and 11 pop. During the flush cycle isq_enq_valid=0 and disp_ready=0.
- Wrap-around flush: entries 0x3E, 0x3F, 0x40, 0x41 (wrap bit set on the last two); flush_robid 0x3F -> count=2. Flush_robid 0x3D with entries 0x3E onward -> count=0.
- Assert reset with count=3 mid-stream -> next cycle count=0, isq_enq_valid=0. After deassert, disp_ready=1.
